packet_builder: RTL and testbench
=================================

// Module: packet_builder
// PURPOSE
//  Transmit-side counterpart of the packet parser. Accepts a header bundle (ETH 16B, IP 20B, TCP 20B)
//  plus a 10-word payload stream, and serializes them onto a 32-bit valid/ready word stream.
//  Appends one CRC-32 word computed over the payload. Sits between packet source logic and the egress FIFO.
// PARAMETERS
//  WIDTH      32  data word width; only 32 supported (elaboration error otherwise)
//  ETH_WORDS   4  ethernet header words
//  IP_WORDS    5  IP header words
//  TCP_WORDS   5  TCP header words
//  PAY_WORDS  10  payload words per packet
// PORTS
//  clk        in   1    clock
//  rst        in   1    reset, asynchronous, active-low
//  eth_hdr    in   128  ethernet header; word i = eth_hdr[32*i +: 32], sent i=0 first
//  ip_hdr     in   160  IP header, same word ordering
//  tcp_hdr    in   160  TCP header, same word ordering
//  hdr_valid  in   1    header bundle valid
//  hdr_ready  out  1    header bundle accepted when hdr_valid&&hdr_ready
//  pay_data   in   32   payload word
//  pay_valid  in   1    payload word valid
//  pay_ready  out  1    payload word accepted when pay_valid&&pay_ready
//  data_out   out  32   output word (registered)
//  valid_out  out  1    data_out valid
//  ready_out  in   1    downstream (FIFO) ready
//  sop_out    out  1    data_out is ETH word 0
//  eop_out    out  1    data_out is CRC word
//  busy       out  1    state != IDLE
// BEHAVIOUR
//  Reset: data_out=0, valid_out=0, sop_out=0, eop_out=0, state=IDLE, counters=0, CRC reg=32'hFFFFFFFF.
//   Outputs hdr_ready and pay_ready are combinational and go low with state=IDLE.
//  adv = !valid_out || ready_out. The output register loads only when adv=1.
//   While valid_out=1 && ready_out=0, data_out, sop_out and eop_out hold stable.
//  FSM states: IDLE -> ETH -> IP -> TCP -> PAYLOAD -> CRC -> IDLE.
//  IDLE:
//   - hdr_ready = adv.
//   - On accept: latch all three headers; data_out=eth word0, sop_out=1, valid_out=1; idx=1; -> ETH.
//   - No accept and adv: valid_out=0.
//   - Latency: header accept edge -> first beat valid the next cycle.
//  ETH/IP/TCP: on adv, emit header word idx, then idx++.
//   - After the last word of a segment: idx=0, move to the next state.
//   - No bubbles are inserted between headers.
//  PAYLOAD:
//   - pay_ready = adv; pay_ready=0 in all other states.
//   - On accept: data_out=pay_data, valid_out=1; CRC updated; pay_cnt++.
//   - adv && !pay_valid: valid_out=0 (bubble); pay_cnt unchanged.
//   - Accept of word PAY_WORDS-1 -> CRC.
//  CRC:
//   - On adv: data_out = ~crc_reg (final value, includes the last payload word); eop_out=1; valid_out=1.
//   - CRC reg reinit to FFFFFFFF; -> IDLE.
//  Back-to-back: the next header may be accepted in the cycle the CRC beat is consumed.
//   Sustained 25 beats per 25 cycles with ready_out=1.
//  CRC-32 definition:
//   - Reflected poly 0xEDB88320, init 0xFFFFFFFF, final xor 0xFFFFFFFF, over payload bytes only.
//   - Byte order per word: [7:0] first, LSB-first bit order.
//  Counters: idx 3 bits (max 4), pay_cnt 4 bits (max 9). Both clear on segment change and never wrap mid-segment.
//  Simultaneous events: hdr_valid is ignored outside IDLE; pay_valid is ignored outside PAYLOAD (no accept, no CRC update).
//  Reset mid-packet: immediate abandon, no eop_out; the downstream FIFO owner flushes the partial packet.
// STRUCTURE
//  pkt_pkg:
//   - state_t enum (3-bit).
//   - ETH/IP/TCP/PAY word-count localparams.
//   - CRC32_POLY, CRC32_INIT.
//   - function crc32_step(crc, word), shared with bench model crc32_ref.
//  Sub-module crc32_accum: clk, rst, init, en, data[31:0] -> crc[31:0].
//   - 1-cycle registered update per enabled word; init has priority over en.
// TESTING
//  1 Header E=128'h0..0F..., IP/TCP incrementing, payload 1..10, ready_out=1 -> 25 beats in 25 cycles.
//    sop_out on beat 0, eop_out on beat 24; beat 0 = eth_hdr[31:0]; CRC beat = crc32_ref(payload).
//  2 ready_out toggled 1/0 randomly -> identical 25-word sequence; data_out stable while stalled; no drop or dup.
//  3 pay_valid low for 3 cycles after payload word 4 -> 3 bubbles (valid_out=0); CRC unchanged vs test 1.
//  4 Two packets back-to-back, hdr_valid held -> second sop_out the cycle after the first eop_out beat is accepted.
//    CRC of packet 2 is independent of packet 1.
//  5 rst low during IP word 2 -> all outputs 0 next cycle, state IDLE; the next packet is sent correctly from ETH word 0.
//  6 Loopback into packet_parser -> parser eth/ip/tcp/payload registers equal the stimulus.

Source files
------------

// File: rtl/packet_builder_pkg.sv
// Shared definitions for the packet builder: FSM state encoding, segment
// word counts and the CRC-32 (reflected) word-step function.
package packet_builder_pkg;

  localparam int ETH_WORDS = 4;
  localparam int IP_WORDS  = 5;
  localparam int TCP_WORDS = 5;
  localparam int PAY_WORDS = 10;

  localparam logic [31:0] CRC32_POLY = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ETH     = 3'd1,
    S_IP      = 3'd2,
    S_TCP     = 3'd3,
    S_PAYLOAD = 3'd4,
    S_CRC     = 3'd5
  } state_t;

  // Byte [7:0] goes first and each byte is LSB-first, so the whole word is
  // simply consumed from bit 0 upward.
  function automatic logic [31:0] crc32_step(input logic [31:0] crc,
                                             input logic [31:0] word);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 32; i++) begin
      if (c[0] ^ word[i]) c = (c >> 1) ^ CRC32_POLY;
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/packet_builder_if.sv
// Handshake bundle of the packet builder.
//   eth_hdr/ip_hdr/tcp_hdr/hdr_valid/hdr_ready : header bundle input
//   pay_data/pay_valid/pay_ready               : payload word input
//   data_out/valid_out/ready_out/sop_out/eop_out: serialized output stream
//   busy                                       : builder not idle
// slave = the builder, master = the packet source / egress side.
interface packet_builder_if;
  logic [127:0] eth_hdr;
  logic [159:0] ip_hdr;
  logic [159:0] tcp_hdr;
  logic         hdr_valid;
  logic         hdr_ready;
  logic [31:0]  pay_data;
  logic         pay_valid;
  logic         pay_ready;
  logic [31:0]  data_out;
  logic         valid_out;
  logic         ready_out;
  logic         sop_out;
  logic         eop_out;
  logic         busy;

  modport slave (
    input  eth_hdr, ip_hdr, tcp_hdr, hdr_valid, pay_data, pay_valid, ready_out,
    output hdr_ready, pay_ready, data_out, valid_out, sop_out, eop_out, busy
  );

  modport master (
    output eth_hdr, ip_hdr, tcp_hdr, hdr_valid, pay_data, pay_valid, ready_out,
    input  hdr_ready, pay_ready, data_out, valid_out, sop_out, eop_out, busy
  );
endinterface

// File: rtl/packet_builder_crc.sv
// CRC-32 accumulator over payload words.
//   clk, rst : clock, async active-low reset (reg -> CRC32_INIT)
//   init     : reload CRC32_INIT (wins over en)
//   en, data : fold one 32-bit word into the running CRC
//   crc      : running (un-inverted) CRC register
module crc32_accum
  import packet_builder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [31:0] data,
  output logic [31:0] crc
);

  logic [31:0] r_crc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      r_crc <= CRC32_INIT;
    else if (init) r_crc <= CRC32_INIT;
    else if (en)   r_crc <= crc32_step(r_crc, data);
  end

  assign crc = r_crc;

endmodule

// File: rtl/packet_builder.sv
// Serializes ETH(4)/IP(5)/TCP(5) header words, 10 payload words and one
// CRC-32 word onto a registered 32-bit valid/ready stream.
//   clk, rst : clock, async active-low reset
//   bus      : packet_builder_if.slave (header in, payload in, stream out)
//
// state     | meaning
// S_IDLE    | waiting for a header bundle; drains last beat
// S_ETH     | emitting ETH words 1..3
// S_IP      | emitting IP words 0..4
// S_TCP     | emitting TCP words 0..4
// S_PAYLOAD | forwarding payload words, bubbles when pay_valid is low
// S_CRC     | emitting inverted CRC word with eop
module packet_builder
  import packet_builder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  packet_builder_if.slave bus
);

  if (WIDTH != 32) begin : g_width_chk
    $error("packet_builder: only WIDTH=32 is supported");
  end

  state_t         r_state;
  logic [2:0]     r_idx;
  logic [3:0]     r_pay_cnt;
  logic [127:0]   r_eth;
  logic [159:0]   r_ip;
  logic [159:0]   r_tcp;
  logic [31:0]    r_data;
  logic           r_valid;
  logic           r_sop;
  logic           r_eop;

  logic           w_adv;
  logic           w_hdr_acc;
  logic           w_pay_acc;
  logic           w_crc_init;
  logic [31:0]    w_crc;

  assign w_adv = !r_valid || bus.ready_out;

  // Ready is held low while reset is asserted even though the state is IDLE.
  assign bus.hdr_ready = rst && (r_state == S_IDLE) && w_adv;
  assign bus.pay_ready = rst && (r_state == S_PAYLOAD) && w_adv;

  assign w_hdr_acc  = bus.hdr_valid && bus.hdr_ready;
  assign w_pay_acc  = bus.pay_valid && bus.pay_ready;
  assign w_crc_init = (r_state == S_CRC) && w_adv;

  crc32_accum u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (w_crc_init),
    .en   (w_pay_acc),
    .data (bus.pay_data),
    .crc  (w_crc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_pay_cnt <= '0;
      r_eth     <= '0;
      r_ip      <= '0;
      r_tcp     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_sop     <= 1'b0;
      r_eop     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hdr_acc) begin
            r_eth   <= bus.eth_hdr;
            r_ip    <= bus.ip_hdr;
            r_tcp   <= bus.tcp_hdr;
            r_data  <= bus.eth_hdr[31:0];
            r_valid <= 1'b1;
            r_sop   <= 1'b1;
            r_eop   <= 1'b0;
            r_idx   <= 3'd1;
            r_state <= S_ETH;
          end else if (w_adv) begin
            r_valid <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
          end
        end
        S_ETH: begin
          if (w_adv) begin
            r_data  <= r_eth[32*r_idx +: 32];
            r_valid <= 1'b1;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            if (r_idx == 3'(ETH_WORDS - 1)) begin
              r_idx   <= '0;
              r_state <= S_IP;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        S_IP: begin
          if (w_adv) begin
            r_data  <= r_ip[32*r_idx +: 32];
            r_valid <= 1'b1;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            if (r_idx == 3'(IP_WORDS - 1)) begin
              r_idx   <= '0;
              r_state <= S_TCP;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        S_TCP: begin
          if (w_adv) begin
            r_data  <= r_tcp[32*r_idx +: 32];
            r_valid <= 1'b1;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            if (r_idx == 3'(TCP_WORDS - 1)) begin
              r_idx   <= '0;
              r_state <= S_PAYLOAD;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        S_PAYLOAD: begin
          if (w_pay_acc) begin
            r_data  <= bus.pay_data;
            r_valid <= 1'b1;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            if (r_pay_cnt == 4'(PAY_WORDS - 1)) begin
              r_pay_cnt <= '0;
              r_state   <= S_CRC;
            end else begin
              r_pay_cnt <= r_pay_cnt + 4'd1;
            end
          end else if (w_adv) begin
            r_valid <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
          end
        end
        S_CRC: begin
          // The accumulator already holds the last payload word here.
          if (w_adv) begin
            r_data  <= ~w_crc;
            r_valid <= 1'b1;
            r_sop   <= 1'b0;
            r_eop   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.data_out  = r_data;
  assign bus.valid_out = r_valid;
  assign bus.sop_out   = r_sop;
  assign bus.eop_out   = r_eop;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_packet_builder.sv
module tb_packet_builder;

  typedef struct {
    int          cyc;
    logic        sop;
    logic        eop;
    logic [31:0] data;
  } beat_t;

  logic clk;
  logic rst;
  packet_builder_if bus ();

  packet_builder #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors;
  int          miscompares;
  int          cyc;
  int          hdr_pending;
  int          hdr_taken;
  int          pay_sent;
  int          pay_total;
  int          pause_at;
  int          pause_left;
  int          bubbles;
  bit          in_pkt;
  bit          prev_stall;
  logic [31:0] prev_data;
  logic        prev_sop;
  logic        prev_eop;
  logic [31:0] pay_q [20];
  beat_t       got[$];
  int          acc_cyc[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] eth_w(input int set, input int i);
    return 32'hE000_0000 | (32'(set) << 20) | 32'(i);
  endfunction
  function automatic logic [31:0] ip_w(input int set, input int i);
    return 32'h4500_0000 | (32'(set) << 20) | 32'(i + 16);
  endfunction
  function automatic logic [31:0] tcp_w(input int set, input int i);
    return 32'h7C00_0000 | (32'(set) << 20) | 32'(i + 32);
  endfunction

  // Independent byte-at-a-time reference CRC over pay_q[base +: 10].
  function automatic logic [31:0] crc32_ref(input int base);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFF_FFFF;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 4; j++) begin
        b = pay_q[base + k][8*j +: 8];
        c = c ^ {24'h0, b};
        for (int n = 0; n < 8; n++)
          c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  function automatic logic [31:0] exp_word(input int set, input int k, input int pbase);
    if (k < 4)       return eth_w(set, k);
    else if (k < 9)  return ip_w(set, k - 4);
    else if (k < 14) return tcp_w(set, k - 9);
    else if (k < 24) return pay_q[pbase + k - 14];
    else             return crc32_ref(pbase);
  endfunction

  task automatic drive_hdr(input int set);
    for (int i = 0; i < 4; i++) bus.eth_hdr[32*i +: 32] = eth_w(set, i);
    for (int i = 0; i < 5; i++) bus.ip_hdr[32*i +: 32]  = ip_w(set, i);
    for (int i = 0; i < 5; i++) bus.tcp_hdr[32*i +: 32] = tcp_w(set, i);
  endtask

  // One clock: inputs set at the falling edge, outputs sampled 1 ns later,
  // transfers take effect at the following rising edge.
  task automatic tick(input bit rdy);
    @(negedge clk);
    cyc++;
    if (prev_stall)
      chk("stall_hold", {29'h0, bus.valid_out, bus.sop_out, bus.eop_out, bus.data_out},
                        {29'h0, 1'b1, prev_sop, prev_eop, prev_data});
    bus.ready_out = rdy;
    bus.hdr_valid = (hdr_pending > 0);
    drive_hdr(hdr_taken % 2);
    if (pay_sent == pause_at) begin
      pause_left = 3;
      pause_at   = -1;
    end
    if (pause_left > 0) begin
      bus.pay_valid = 1'b0;
      pause_left--;
    end else begin
      bus.pay_valid = (pay_sent < pay_total);
    end
    bus.pay_data = (pay_sent < 20) ? pay_q[pay_sent] : 32'h0;
    #1;
    if (in_pkt && !bus.valid_out) bubbles++;
    if (bus.valid_out && bus.sop_out) in_pkt = 1'b1;
    if (bus.valid_out && bus.ready_out) begin
      got.push_back('{cyc, bus.sop_out, bus.eop_out, bus.data_out});
      if (bus.eop_out) in_pkt = 1'b0;
    end
    prev_stall = bus.valid_out && !bus.ready_out;
    prev_data  = bus.data_out;
    prev_sop   = bus.sop_out;
    prev_eop   = bus.eop_out;
    if (bus.hdr_valid && bus.hdr_ready) begin
      acc_cyc.push_back(cyc);
      hdr_taken++;
      hdr_pending--;
    end
    if (bus.pay_valid && bus.pay_ready) pay_sent++;
  endtask

  task automatic run_until(input int n, input int max_ticks, input bit rnd, input string tag);
    int t;
    t = 0;
    while (got.size() < n && t < max_ticks) begin
      tick(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      t++;
    end
    chk({tag, "_beats"}, 64'(got.size() >= n), 64'd1);
  endtask

  task automatic verify_pkt(input int start, input int set, input int pbase, input string tag);
    if (got.size() < start + 25) return;
    for (int k = 0; k < 25; k++)
      chk($sformatf("%s_beat%0d", tag, k),
          {30'h0, got[start + k].sop, got[start + k].eop, got[start + k].data},
          {30'h0, 1'(k == 0), 1'(k == 24), exp_word(set, k, pbase)});
  endtask

  task automatic new_pkt(input int n_hdr, input int n_pay);
    got.delete();
    acc_cyc.delete();
    hdr_pending = n_hdr;
    hdr_taken   = 0;
    pay_sent    = 0;
    pay_total   = n_pay;
    bubbles     = 0;
    in_pkt      = 1'b0;
    prev_stall  = 1'b0;
  endtask

  initial begin
    bit found;
    vectors = 0; miscompares = 0; cyc = 0;
    pause_at = -1; pause_left = 0;
    for (int i = 0; i < 10; i++) pay_q[i] = 32'(i + 1);
    for (int i = 10; i < 20; i++) pay_q[i] = 32'hA500_0000 | 32'((i - 10) * 32'h0001_0203);
    rst = 1'b0;
    bus.hdr_valid = 1'b0; bus.pay_valid = 1'b0; bus.pay_data = '0;
    bus.ready_out = 1'b1;
    drive_hdr(0);
    new_pkt(0, 0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_state", {57'h0, bus.valid_out, bus.sop_out, bus.eop_out, bus.busy,
                        bus.hdr_ready, bus.pay_ready, |bus.data_out}, 64'h0);
    rst = 1'b1;
    tick(1'b1);
    chk("idle_hdr_ready", {62'h0, bus.hdr_ready, bus.busy}, 64'h2);

    // 1: full-rate packet
    new_pkt(1, 10);
    run_until(25, 100, 1'b0, "t1");
    verify_pkt(0, 0, 0, "t1");
    if (got.size() >= 25) begin
      chk("t1_span", 64'(got[24].cyc - got[0].cyc), 64'd24);
      chk("t1_latency", 64'(got[0].cyc - acc_cyc[0]), 64'd1);
    end
    chk("t1_bubbles", 64'(bubbles), 64'd0);
    tick(1'b1); tick(1'b1);
    chk("t1_idle", {62'h0, bus.valid_out, bus.busy}, 64'h0);

    // 2: random backpressure
    new_pkt(1, 10);
    run_until(25, 400, 1'b1, "t2");
    verify_pkt(0, 0, 0, "t2");
    chk("t2_no_dup", 64'(got.size()), 64'd25);
    tick(1'b1); tick(1'b1);

    // 3: three-cycle payload gap after the fifth payload word
    new_pkt(1, 10);
    pause_at = 5;
    run_until(25, 100, 1'b0, "t3");
    verify_pkt(0, 0, 0, "t3");
    chk("t3_bubbles", 64'(bubbles), 64'd3);
    tick(1'b1); tick(1'b1);

    // 4: back-to-back packets with hdr_valid held high
    new_pkt(2, 20);
    run_until(50, 200, 1'b0, "t4");
    verify_pkt(0, 0, 0, "t4a");
    verify_pkt(25, 1, 10, "t4b");
    if (got.size() >= 50) begin
      chk("t4_b2b_gap", 64'(got[25].cyc - got[24].cyc), 64'd1);
      chk("t4_span", 64'(got[49].cyc - got[0].cyc), 64'd49);
    end
    chk("t4_hdr_count", 64'(hdr_taken), 64'd2);
    tick(1'b1); tick(1'b1);

    // 5: reset while IP word 2 is on the bus
    new_pkt(1, 10);
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      tick(1'b1);
      if (bus.valid_out && bus.data_out == ip_w(0, 2)) found = 1'b1;
    end
    chk("t5_reached_ip2", 64'(found), 64'd1);
    rst = 1'b0;
    #1;
    chk("t5_reset_now", {57'h0, bus.valid_out, bus.sop_out, bus.eop_out, bus.busy,
                         bus.hdr_ready, bus.pay_ready, |bus.data_out}, 64'h0);
    @(negedge clk);
    chk("t5_reset_next", {59'h0, bus.valid_out, bus.eop_out, bus.busy, |bus.data_out, 1'b0}, 64'h0);
    rst = 1'b1;
    new_pkt(1, 10);
    run_until(25, 100, 1'b0, "t5");
    verify_pkt(0, 0, 0, "t5");
    tick(1'b1); tick(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
